// File: rtl/dpram_sync_pkg.sv
// Shared types and helpers for the synchronous dual-port RAM (optional parity: DPRAM_PARITY_EN).
// The core's defines.v macros are provided here, guarded, so this slice also builds standalone.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CHIP_ENABLE
`define CHIP_ENABLE 1'b1
`endif
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif
`ifndef ZERO
`define ZERO 32'h0000_0000
`endif
`ifndef SIZE_BYTE
`define SIZE_BYTE 2'b00
`endif
`ifndef SIZE_HALF
`define SIZE_HALF 2'b01
`endif
`ifndef SIZE_WORD
`define SIZE_WORD 2'b10
`endif

package dpram_sync_pkg;

   localparam int LANES = 4;

   // bit/element k is byte lane k, i.e. byte offset k within the word
   typedef logic [LANES-1:0]      lane_mask_t;
   typedef logic [LANES-1:0][7:0] lane_data_t;

   typedef struct packed {
      logic       vld;
      logic       err;
      logic       load;
      logic [1:0] size;
      logic [1:0] off;
      logic       sext;
   } d_resp_t;

   function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
      case (size)
         `SIZE_BYTE: return 1'b0;
         `SIZE_HALF: return off[0];
         `SIZE_WORD: return |off;
         default:    return 1'b1;
      endcase
   endfunction

   function automatic lane_mask_t lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         `SIZE_BYTE: return lane_mask_t'(1) << off;
         `SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

   // Big-endian extraction: lane 0 is the most significant byte of the word.
   function automatic logic [31:0] extend(input lane_data_t d, input logic [1:0] size,
                                          input logic [1:0] off, input logic sext);
      logic [7:0]  bv;
      logic [15:0] hv;
      bv = d[off];
      hv = off[1] ? {d[2], d[3]} : {d[0], d[1]};
      case (size)
         `SIZE_BYTE: return {{24{sext & bv[7]}}, bv};
         `SIZE_HALF: return {{16{sext & hv[15]}}, hv};
         default:    return {d[0], d[1], d[2], d[3]};
      endcase
   endfunction

endpackage

// File: rtl/dpram_sync_if.sv
// Request/response bundle between the core (master) and dpram_sync (slave).
// Parity error outputs are only meaningful when DPRAM_PARITY_EN is defined.
interface dpram_if;
   import dpram_sync_pkg::*;

   logic                   d_ce_in;
   logic                   d_we_in;
   logic [`ADDR_WIDTH-1:0] d_addr_in;
   logic [1:0]             d_size_in;
   logic                   d_sext_in;
   logic [`DATA_WIDTH-1:0] d_wdata_in;
   logic [`DATA_WIDTH-1:0] d_rdata_out;
   logic                   d_rvalid_out;
   logic                   d_err_out;
   logic                   d_perr_out;

   logic                   i_ce_in;
   logic                   i_hold_in;
   logic [`ADDR_WIDTH-1:0] i_addr_in;
   logic [`DATA_WIDTH-1:0] i_rdata_out;
   logic                   i_rvalid_out;
   logic                   i_err_out;
   logic                   i_perr_out;

   modport master (
      output d_ce_in, d_we_in, d_addr_in, d_size_in, d_sext_in, d_wdata_in,
      output i_ce_in, i_hold_in, i_addr_in,
      input  d_rdata_out, d_rvalid_out, d_err_out, d_perr_out,
      input  i_rdata_out, i_rvalid_out, i_err_out, i_perr_out
   );

   modport slave (
      input  d_ce_in, d_we_in, d_addr_in, d_size_in, d_sext_in, d_wdata_in,
      input  i_ce_in, i_hold_in, i_addr_in,
      output d_rdata_out, d_rvalid_out, d_err_out, d_perr_out,
      output i_rdata_out, i_rvalid_out, i_err_out, i_perr_out
   );
endinterface

// File: rtl/dpram_sync_bank.sv
// One byte lane: single write port, two enabled synchronous read ports (read-before-write).
// DPRAM_PARITY_EN adds an even-parity bit per entry and a registered mismatch flag per port.
module dpram_bank
   import dpram_sync_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          en_a,
   input  logic [AW-1:0] raddr_a,
   output logic [7:0]    rdata_a,
   output logic          perr_a,
   input  logic          en_b,
   input  logic [AW-1:0] raddr_b,
   output logic [7:0]    rdata_b,
   output logic          perr_b
);
   logic [7:0] mem [DEPTH];

   // plain always: the backdoor tasks below also update this array
   always @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (en_a) rdata_a <= mem[raddr_a];
      if (en_b) rdata_b <= mem[raddr_b];
   end

`ifdef DPRAM_PARITY_EN
   logic par [DEPTH];
   logic par_a, par_b;

   always @(posedge clk) begin
      if (we) par[waddr] <= ^wdata;
   end

   always_ff @(posedge clk) begin
      if (en_a) par_a <= par[raddr_a];
      if (en_b) par_b <= par[raddr_b];
   end

   assign perr_a = par_a ^ (^rdata_a);
   assign perr_b = par_b ^ (^rdata_b);
`else
   assign perr_a = 1'b0;
   assign perr_b = 1'b0;
`endif

   function automatic logic [7:0] peek(input logic [AW-1:0] idx);
      return mem[idx];
   endfunction

   task automatic write_byte(input logic [AW-1:0] idx, input logic [7:0] val);
      mem[idx] <= val;
`ifdef DPRAM_PARITY_EN
      par[idx] <= ^val;
`endif
   endtask

   // Data-only write: leaves any stored parity stale to model a bit upset.
   task automatic poke(input logic [AW-1:0] idx, input logic [7:0] val);
      mem[idx] <= val;
   endtask

endmodule

// File: rtl/dpram_sync.sv
// Synchronous-read dual-port RAM: data port with sub-word big-endian access, word-only fetch port.
// DPRAM_PARITY_EN enables per-byte parity and the *_perr_out flags.
module dpram_sync
   import dpram_sync_pkg::*;
#(
   parameter int RAM_SIZE       = 4096,
   parameter int RAM_ADDR_WIDTH = 12
) (
   input logic    clk_in,
   input logic    rst_in,
   dpram_if.slave bus
);
   localparam int DEPTH = RAM_SIZE / 4;
   localparam int IW    = RAM_ADDR_WIDTH - 2;

   logic [IW-1:0] d_idx, i_idx;
   logic [1:0]    d_off;
   logic          d_ce, d_bad, d_store, d_load, i_ce, i_req, i_ok;
   lane_mask_t    wr_lanes, perr_a, perr_b;
   lane_data_t    wr_data, rd_a, rd_b;
   d_resp_t       d_q;
   logic          i_vld_q, i_err_q;

   assign d_idx   = bus.d_addr_in[RAM_ADDR_WIDTH-1:2];
   assign d_off   = bus.d_addr_in[1:0];
   assign i_idx   = bus.i_addr_in[RAM_ADDR_WIDTH-1:2];
   assign d_ce    = (bus.d_ce_in == `CHIP_ENABLE);
   assign i_ce    = (bus.i_ce_in == `CHIP_ENABLE);
   assign d_bad   = access_err(bus.d_size_in, d_off);
   assign d_store = d_ce && !rst_in && (bus.d_we_in == `WRITE_ENABLE) && !d_bad;
   assign d_load  = d_ce && !rst_in && (bus.d_we_in != `WRITE_ENABLE) && !d_bad;
   assign i_req   = i_ce && !bus.i_hold_in && !rst_in;

   assign wr_lanes = d_store ? lane_mask(bus.d_size_in, d_off) : '0;

   // Every lane sees the byte it would take for this size; wr_lanes picks the ones written.
   always_comb begin
      wr_data = '0;
      for (int k = 0; k < LANES; k++) begin
         case (bus.d_size_in)
            `SIZE_WORD: wr_data[k] = bus.d_wdata_in[31-8*k -: 8];
            `SIZE_HALF: wr_data[k] = k[0] ? bus.d_wdata_in[7:0] : bus.d_wdata_in[15:8];
            default:    wr_data[k] = bus.d_wdata_in[7:0];
         endcase
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      dpram_bank #(.DEPTH(DEPTH), .AW(IW)) u_bank (
         .clk     (clk_in),
         .we      (wr_lanes[k]),
         .waddr   (d_idx),
         .wdata   (wr_data[k]),
         .en_a    (d_load),
         .raddr_a (d_idx),
         .rdata_a (rd_a[k]),
         .perr_a  (perr_a[k]),
         .en_b    (i_req),
         .raddr_b (i_idx),
         .rdata_b (rd_b[k]),
         .perr_b  (perr_b[k])
      );
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         d_q     <= '0;
         i_vld_q <= 1'b0;
         i_err_q <= 1'b0;
      end else begin
         d_q.vld  <= d_ce;
         d_q.err  <= d_ce && d_bad;
         d_q.load <= d_load;
         d_q.size <= bus.d_size_in;
         d_q.off  <= d_off;
         d_q.sext <= bus.d_sext_in;
         if (!bus.i_hold_in) begin
            i_vld_q <= i_ce;
            i_err_q <= i_ce && (bus.i_addr_in[1:0] != 2'b00);
         end
      end
   end

   assign bus.d_rvalid_out = d_q.vld;
   assign bus.d_err_out    = d_q.err;
   assign bus.d_rdata_out  = d_q.load ? extend(rd_a, d_q.size, d_q.off, d_q.sext) : `ZERO;
   assign bus.d_perr_out   = d_q.load && |(perr_a & lane_mask(d_q.size, d_q.off));

   // Bank read registers only advance on i_req, so a hold freezes the word as well.
   assign i_ok             = i_vld_q && !i_err_q;
   assign bus.i_rvalid_out = i_vld_q;
   assign bus.i_err_out    = i_err_q;
   assign bus.i_rdata_out  = i_ok ? {rd_b[0], rd_b[1], rd_b[2], rd_b[3]} : `ZERO;
   assign bus.i_perr_out   = i_ok && |perr_b;

   if (`ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_addr_hi
      logic unused_hi;
      assign unused_hi = ^{bus.d_addr_in[`ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                           bus.i_addr_in[`ADDR_WIDTH-1:RAM_ADDR_WIDTH]};
   end

   task automatic readByte(input logic [`ADDR_WIDTH-1:0] byte_addr, output logic [7:0] val);
      logic [IW-1:0] idx;
      idx = byte_addr[RAM_ADDR_WIDTH-1:2];
      case (byte_addr[1:0])
         2'd0:    val = g_lane[0].u_bank.peek(idx);
         2'd1:    val = g_lane[1].u_bank.peek(idx);
         2'd2:    val = g_lane[2].u_bank.peek(idx);
         default: val = g_lane[3].u_bank.peek(idx);
      endcase
   endtask

   task automatic writeByte(input logic [`ADDR_WIDTH-1:0] byte_addr, input logic [7:0] val);
      logic [IW-1:0] idx;
      idx = byte_addr[RAM_ADDR_WIDTH-1:2];
      case (byte_addr[1:0])
         2'd0:    g_lane[0].u_bank.write_byte(idx, val);
         2'd1:    g_lane[1].u_bank.write_byte(idx, val);
         2'd2:    g_lane[2].u_bank.write_byte(idx, val);
         default: g_lane[3].u_bank.write_byte(idx, val);
      endcase
   endtask

endmodule

// File: tb/tb_dpram_sync.sv
// Bench for dpram_sync: byte-array reference model compared every cycle, directed cases, random traffic.
// Parity cases are included when DPRAM_PARITY_EN is defined.
module tb_dpram_sync;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   dpram_if bus();

   dpram_sync #(.RAM_SIZE(4096), .RAM_ADDR_WIDTH(12)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem_m [4096];
   bit          badp [4096];
   logic [31:0] ei_rdata = 0;
   logic        ei_vld = 0, ei_err = 0, ei_perr = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic dreq(input bit ce, input bit we, input logic [31:0] addr, input logic [1:0] sz,
                       input bit sx, input logic [31:0] wd);
      bus.d_ce_in = ce; bus.d_we_in = we; bus.d_addr_in = addr;
      bus.d_size_in = sz; bus.d_sext_in = sx; bus.d_wdata_in = wd;
   endtask

   task automatic ireq(input bit ce, input bit hold, input logic [31:0] addr);
      bus.i_ce_in = ce; bus.i_hold_in = hold; bus.i_addr_in = addr;
   endtask

   // Expected outputs follow from the byte-array view: fetch reads before the store lands.
   task automatic cycle();
      logic [31:0] nd, v;
      logic        nvd, ned, npd;
      int          a, n;
      nd = 0; nvd = 0; ned = 0; npd = 0;
      if (rst) begin
         ei_rdata = 0; ei_vld = 0; ei_err = 0; ei_perr = 0;
      end else begin
         if (!bus.i_hold_in) begin
            ei_rdata = 0; ei_vld = 0; ei_err = 0; ei_perr = 0;
            if (bus.i_ce_in) begin
               a = int'(bus.i_addr_in & 32'hFFF);
               ei_vld = 1;
               ei_err = (a % 4) != 0;
               if (!ei_err)
                  for (int j = 0; j < 4; j++) begin
                     ei_rdata = (ei_rdata << 8) | 32'(mem_m[a+j]);
                     ei_perr  = ei_perr | badp[a+j];
                  end
            end
         end
         if (bus.d_ce_in) begin
            a = int'(bus.d_addr_in & 32'hFFF);
            n = 1 << bus.d_size_in;
            nvd = 1;
            ned = (bus.d_size_in == 2'd3) || (a % n != 0);
            if (!ned && bus.d_we_in) begin
               for (int j = 0; j < n; j++) begin
                  mem_m[a+j] = 8'(bus.d_wdata_in >> (8*(n-1-j)));
                  badp[a+j]  = 0;
               end
            end else if (!ned) begin
               v = 0;
               for (int j = 0; j < n; j++) begin
                  v   = (v << 8) | 32'(mem_m[a+j]);
                  npd = npd | badp[a+j];
               end
               if (bus.d_sext_in && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
               nd = v;
            end
         end
      end
`ifndef DPRAM_PARITY_EN
      npd = 0; ei_perr = 0;
`endif
      @(posedge clk);
      #1;
      chk("d_rdata",  bus.d_rdata_out, nd);
      chk("d_rvalid", 32'(bus.d_rvalid_out), 32'(nvd));
      chk("d_err",    32'(bus.d_err_out), 32'(ned));
      chk("d_perr",   32'(bus.d_perr_out), 32'(npd));
      chk("i_rdata",  bus.i_rdata_out, ei_rdata);
      chk("i_rvalid", 32'(bus.i_rvalid_out), 32'(ei_vld));
      chk("i_err",    32'(bus.i_err_out), 32'(ei_err));
      chk("i_perr",   32'(bus.i_perr_out), 32'(ei_perr));
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] addr;
      logic [1:0]  sz;

      dreq(0, 0, 0, 0, 0, 0);
      ireq(0, 0, 0);
      for (int i = 0; i < 4096; i++) begin
         b = 8'($urandom);
         mem_m[i] = b;
         badp[i]  = 0;
         dut.writeByte(32'(i), b);
      end
      mem_m[32'h80] = 8'h5A;
      dut.writeByte(32'h80, 8'h5A);
      #1;

      // store while in reset must be dropped
      dreq(1, 1, 32'h80, 2'd2, 0, 32'hCAFE_F00D);
      cycle();
      cycle();
      chk("rst_d_rvalid", 32'(bus.d_rvalid_out), 32'h0);
      dut.readByte(32'h80, b);
      chk("rst_store_dropped", 32'(b), 32'h5A);
      dut.readByte(32'h1080, b);
      chk("backdoor_wrap", 32'(b), 32'h5A);
      rst = 0;

      dreq(1, 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF); cycle();
      chk("st_rvalid", 32'(bus.d_rvalid_out), 32'h1);
      chk("st_rdata", bus.d_rdata_out, 32'h0);
      dreq(1, 0, 32'h10, 2'd2, 0, 0); ireq(1, 0, 32'h10); cycle();
      chk("ld_word", bus.d_rdata_out, 32'hDEAD_BEEF);
      chk("if_word", bus.i_rdata_out, 32'hDEAD_BEEF);
      ireq(0, 0, 0);

      dreq(1, 1, 32'h10, 2'd2, 0, 32'h1122_3344); cycle();
      dreq(1, 1, 32'h13, 2'd0, 0, 32'h0000_0080); cycle();
      dreq(1, 0, 32'h10, 2'd2, 0, 0); cycle();
      chk("byte_st_word", bus.d_rdata_out, 32'h1122_3380);
      dreq(1, 0, 32'h13, 2'd0, 1, 0); cycle();
      chk("ld_byte_sext", bus.d_rdata_out, 32'hFFFF_FF80);
      dreq(1, 0, 32'h13, 2'd0, 0, 0); cycle();
      chk("ld_byte_zext", bus.d_rdata_out, 32'h0000_0080);

      dreq(1, 1, 32'h22, 2'd1, 0, 32'h0000_A5A5); cycle();
      dreq(1, 0, 32'h20, 2'd2, 0, 0); cycle();
      chk("half_st_low", bus.d_rdata_out & 32'hFFFF, 32'hA5A5);
      dreq(1, 0, 32'h21, 2'd1, 1, 0); cycle();
      chk("half_misalign_err", 32'(bus.d_err_out), 32'h1);
      chk("half_misalign_data", bus.d_rdata_out, 32'h0);
      dreq(1, 1, 32'h22, 2'd2, 0, 32'h5566_7788); cycle();
      chk("word_misalign_err", 32'(bus.d_err_out), 32'h1);
      dreq(1, 0, 32'h20, 2'd2, 0, 0); cycle();
      chk("misalign_no_write", bus.d_rdata_out & 32'hFFFF, 32'hA5A5);
      dreq(1, 0, 32'h22, 2'd1, 1, 0); cycle();
      chk("ld_half_sext", bus.d_rdata_out, 32'hFFFF_A5A5);

      dreq(1, 1, 32'h40, 2'd2, 0, 32'hAAAA_5555); cycle();
      dreq(1, 1, 32'h40, 2'd2, 0, 32'h1234_5678); ireq(1, 0, 32'h40); cycle();
      chk("collide_old", bus.i_rdata_out, 32'hAAAA_5555);
      dreq(0, 0, 0, 0, 0, 0); cycle();
      chk("collide_new", bus.i_rdata_out, 32'h1234_5678);
      ireq(1, 0, 32'h10); cycle();
      for (int i = 0; i < 3; i++) begin
         ireq(1, 1, 32'h40); cycle();
         chk("hold_stable", bus.i_rdata_out, 32'h1122_3380);
      end
      ireq(1, 0, 32'h42); cycle();
      chk("if_misalign", 32'(bus.i_err_out), 32'h1);
      ireq(0, 0, 0);

      dreq(1, 1, 32'h1004, 2'd2, 0, 32'h0BAD_F00D); cycle();
      dreq(1, 0, 32'h0004, 2'd2, 0, 0); cycle();
      chk("wrap_alias", bus.d_rdata_out, 32'h0BAD_F00D);

      // reset on the edge where a response would appear
      dreq(1, 0, 32'h10, 2'd2, 0, 0); ireq(1, 1, 32'h10); rst = 1; cycle();
      chk("rst_kills_resp", 32'(bus.d_rvalid_out), 32'h0);
      chk("rst_over_hold", 32'(bus.i_rvalid_out), 32'h0);
      rst = 0; ireq(0, 0, 0);

`ifdef DPRAM_PARITY_EN
      dreq(1, 1, 32'h50, 2'd2, 0, 32'h0102_0304); cycle();
      dut.g_lane[1].u_bank.poke(10'h14, 8'h03);
      mem_m[32'h51] = 8'h03; badp[32'h51] = 1;
      #1;
      dreq(1, 0, 32'h51, 2'd0, 0, 0); cycle();
      chk("perr_bad_lane", 32'(bus.d_perr_out), 32'h1);
      dreq(1, 0, 32'h52, 2'd0, 0, 0); cycle();
      chk("perr_good_lane", 32'(bus.d_perr_out), 32'h0);
`endif

      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(63) == 0);
         sz = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
         addr = 32'($urandom_range(255));
         if ($urandom_range(4) != 0) addr = addr & ~32'(7 >> (3 - sz));
         if ($urandom_range(15) == 0) addr = addr | ($urandom << 12);
         dreq(($urandom_range(3) != 0), 1'($urandom_range(1)), addr, sz,
              1'($urandom_range(1)), $urandom);
         addr = 32'($urandom_range(255));
         if ($urandom_range(7) != 0) addr = addr & ~32'h3;
         if ($urandom_range(15) == 0) addr = addr | ($urandom << 12);
         ireq(($urandom_range(3) != 0), ($urandom_range(3) == 0), addr);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
